// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with a double-buffered display word,
// leading-zero blanking and configurable segment/anode polarity.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int HEX_MODE       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  input  logic                      enable,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]             presc;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   shadow_data, pend_data;
  logic [NUM_DIGITS-1:0]     shadow_dp, pend_dp;
  logic                      pend_valid;

  logic                      tick, wrap;
  logic [3:0]                cur_code;
  logic                      cur_dp;
  logic [NUM_DIGITS-1:0]     an_sel;
  logic                      lz_run, blank;
  logic [6:0]                seg_pre;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    if (HEX_MODE == 0 && c > 4'd9) s = '0;
    return s;
  endfunction

  assign tick = (presc == PW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  always_comb begin
    cur_code = '0;
    cur_dp   = 1'b0;
    an_sel   = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_code  = shadow_data[4*k +: 4];
        cur_dp    = shadow_dp[k];
        an_sel[k] = 1'b1;
      end
    end
    // Run of zeros from the top digit down; digit 0 is outside the loop so never blanks.
    lz_run = blank_lz;
    blank  = 1'b0;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run = lz_run & (shadow_data[4*k +: 4] == 4'd0);
      if (idx == IW'(k)) blank = lz_run;
    end
    seg_pre = blank ? 7'd0 : decode(cur_code);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      seg         <= SEG_OFF;
      dp          <= DP_OFF;
      an          <= AN_OFF;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        presc <= '0;
        idx   <= wrap ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      if (load) begin
        pend_data  <= data_in;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
      // A load coinciding with the boundary bypasses the pending buffer.
      if (wrap) begin
        if (load) begin
          shadow_data <= data_in;
          shadow_dp   <= dp_in;
          pend_valid  <= 1'b0;
        end else if (pend_valid) begin
          shadow_data <= pend_data;
          shadow_dp   <= pend_dp;
          pend_valid  <= 1'b0;
        end
      end

      seg <= seg_pre ^ SEG_OFF;
      dp  <= cur_dp ^ DP_OFF;
      an  <= (enable ? an_sel : '0) ^ AN_OFF;
    end
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display bank. It captures a packed hex/BCD word through a load strobe and double-buffers it so updates apply only at frame boundaries. It scans one digit per refresh slot with optional leading-zero blanking and configurable output polarity. It sits between the datapath (counters, squarer results) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
REFRESH_DIV, 50000, clk cycles per digit slot (>=1)
HEX_MODE, 1, 1: codes 10-15 render A,b,C,d,E,F; 0: codes 10-15 render all segments off
SEG_ACTIVE_LOW, 0, 1: invert seg and dp at the pins
AN_ACTIVE_LOW, 1, 1: an bit low selects the digit

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  capture data_in/dp_in into pending buffer
data_in  input  4*NUM_DIGITS  digit codes, digit k = data_in[4k+3:4k], digit 0 rightmost
dp_in  input  NUM_DIGITS  decimal point per digit
blank_lz  input  1  leading-zero blanking enable
enable  input  1  0: all anodes deselected, scan continues
seg  output  7  segments, seg[6]=a ... seg[0]=g
dp  output  1  decimal point of active digit
an  output  NUM_DIGITS  digit select, one-hot (polarity per AN_ACTIVE_LOW)
frame_done  output  1  one-cycle pulse when scan wraps from digit NUM_DIGITS-1 to 0

Behaviour:
- Reset (async assert, sync release): prescaler=0, idx=0, shadow and pending buffers=0, pending_valid=0. seg/dp "off", an all deselected, frame_done=0. All of these use polarity-adjusted values.
- Prescaler counts 0..REFRESH_DIV-1. At terminal count it returns to 0 and idx advances; idx wraps NUM_DIGITS-1 -> 0. REFRESH_DIV=1 advances idx every cycle.
- frame_done is registered: high exactly in the cycle after idx changes from NUM_DIGITS-1 to 0. With NUM_DIGITS=1 it pulses every REFRESH_DIV cycles.
- load: pending <= {data_in, dp_in}, pending_valid <= 1. A later load before the boundary overwrites pending (last wins).
- Frame boundary is the cycle in which idx wraps to 0:
  - if pending_valid, shadow <= pending and pending_valid <= 0.
  - if load is high in that same cycle, shadow <= data_in/dp_in directly and pending_valid <= 0.
- Outputs are registered from (idx, shadow), so seg/dp/an reflect an idx change one clk later. an is one-hot on idx. If enable=0, an is all deselected next cycle while seg/dp still track.
- Segment map (a..g, active-high before inversion): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111. HEX_MODE=0 maps 10-15 to 0000000.
- Leading-zero blanking (blank_lz=1): starting at digit NUM_DIGITS-1 and moving down, each digit whose code is 0 is blanked (seg off) until the first nonzero digit. Digit 0 is never blanked. dp is unaffected by blanking.
- Reset mid-scan: all state returns to reset values immediately. The first post-reset display is digit 0 = "0", with an valid in the cycle after the first clk edge after release.

Test Plan:
- Reset, NUM_DIGITS=4, REFRESH_DIV=4, enable=1 -> an cycles 1110,1101,1011,0111 (active-low), 4 clk per digit. seg=1111110 on all digits. frame_done pulses every 16 clk.
- load data_in=16'h12AF mid-frame -> display stays 0000 until the next frame_done. Then digits 0..3 show 1000111, 1110111, 1101101, 0110000. With HEX_MODE=0, digits 0 and 1 show 0000000.
- Two loads in one frame (16'h1111 then 16'h2222), then load 16'h3333 in the wrap cycle -> shadow becomes 3333 at that boundary; 1111 is never displayed.
- blank_lz=1, data 16'h0050 -> digits 3 and 2 blank, digit 1 = 1011011, digit 0 = 1111110. Data 16'h0000 -> only digit 0 lit.
- SEG_ACTIVE_LOW=1, dp_in=4'b0100 -> on digit 2 dp=0, elsewhere dp=1. seg is the bitwise inverse of the table. enable=0 -> an=1111 next cycle.
- Assert rst_n low mid-digit 2 -> outputs go to reset values asynchronously. After release the scan restarts at digit 0 showing 0.
